// File: rtl/filter_sequencer.sv
// filter_sequencer
//   Walks every bin of a spectrum RAM through an external combinational
//   low-pass filter and writes each result back in place. Each bin takes
//   three cycles: a RAM read, a capture of the returned sample, and a write.
//
// Parameters
//   NUM_BINS : number of FFT bins in the RAM (power of two, 4..256)
//   MIRROR   : 1 = fold bins at or above NUM_BINS/2 onto their
//              negative-frequency distance; 0 = raw bin index
//
// Ports
//   clk                       : single clock, rising edge
//   rst                       : asynchronous active-high reset
//   start                     : request one pass, sampled only in IDLE
//   cutoff_freq               : cutoff bin, latched on the accepted start
//   busy                      : pass in progress
//   done                      : one-cycle pulse when a pass completes
//   ram_addr                  : RAM address for both read and write
//   ram_rd_en                 : read strobe, data returns one cycle later
//   ram_rd_real/ram_rd_imag   : RAM read data
//   ram_wr_en                 : write strobe
//   ram_wr_real/ram_wr_imag   : RAM write data (the filter result)
//   filt_freq_bin             : bin index presented to the filter
//   filt_cutoff               : latched cutoff presented to the filter
//   filt_real_in/filt_imag_in : captured sample presented to the filter
//   filt_real_out/imag_out    : filter result, combinational on its inputs
module filter_sequencer #(
    parameter int NUM_BINS = 256,
    parameter int MIRROR   = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  cutoff_freq,
    output logic        busy,
    output logic        done,
    output logic [7:0]  ram_addr,
    output logic        ram_rd_en,
    input  logic [15:0] ram_rd_real,
    input  logic [15:0] ram_rd_imag,
    output logic        ram_wr_en,
    output logic [15:0] ram_wr_real,
    output logic [15:0] ram_wr_imag,
    output logic [7:0]  filt_freq_bin,
    output logic [7:0]  filt_cutoff,
    output logic [15:0] filt_real_in,
    output logic [15:0] filt_imag_in,
    input  logic [15:0] filt_real_out,
    input  logic [15:0] filt_imag_out
);

    localparam int IW = $clog2(NUM_BINS);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_BINS - 1);
    // NUM_BINS reduced mod 256: for 256 this is 0, and 0 - idx in 8 bits
    // still yields 256 - idx because the folded result never exceeds 128.
    localparam logic [7:0] NB8 = 8'(NUM_BINS);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] CAP  = 3'd2;
    localparam logic [2:0] WR   = 3'd3;
    localparam logic [2:0] FIN  = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [IW-1:0] idx;
    logic [7:0]    cutoff_q;
    logic [15:0]   sample_re;
    logic [15:0]   sample_im;
    logic [7:0]    idx8;

    assign idx8 = 8'(idx);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RD;
            RD:      state_nxt = CAP;
            CAP:     state_nxt = WR;
            WR:      state_nxt = (idx == LAST_IDX) ? FIN : RD;
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            cutoff_q  <= '0;
            sample_re <= '0;
            sample_im <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (start) begin
                        cutoff_q <= cutoff_freq;
                        idx      <= '0;
                    end
                end
                CAP: begin
                    sample_re <= ram_rd_real;
                    sample_im <= ram_rd_imag;
                end
                WR: begin
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // RAM strobes and address are decoded from state only, so reset
    // clears them immediately.
    always_comb begin
        ram_addr    = '0;
        ram_rd_en   = 1'b0;
        ram_wr_en   = 1'b0;
        ram_wr_real = '0;
        ram_wr_imag = '0;
        case (state)
            RD: begin
                ram_addr  = idx8;
                ram_rd_en = 1'b1;
            end
            WR: begin
                ram_addr    = idx8;
                ram_wr_en   = 1'b1;
                ram_wr_real = filt_real_out;
                ram_wr_imag = filt_imag_out;
            end
            default: ;
        endcase
    end

    assign busy = (state == RD) || (state == CAP) || (state == WR);
    assign done = (state == FIN);

    // idx MSB set means idx >= NUM_BINS/2.
    always_comb begin
        if ((MIRROR != 0) && idx[IW-1])
            filt_freq_bin = NB8 - idx8;
        else
            filt_freq_bin = idx8;
    end

    assign filt_cutoff  = cutoff_q;
    assign filt_real_in = sample_re;
    assign filt_imag_in = sample_im;

endmodule

// File: tb/tb_filter_sequencer.sv
module tb_filter_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       start;
    logic [7:0] cutoff;

    // index 0: MIRROR=1 instance, index 1: MIRROR=0 instance
    logic        busy[2];
    logic        done[2];
    logic [7:0]  ram_addr[2];
    logic        rd_en[2];
    logic        wr_en[2];
    logic [15:0] rd_re[2];
    logic [15:0] rd_im[2];
    logic [15:0] wr_re[2];
    logic [15:0] wr_im[2];
    logic [7:0]  fbin[2];
    logic [7:0]  fcut[2];
    logic [15:0] fin_re[2];
    logic [15:0] fin_im[2];
    logic [15:0] fout_re[2];
    logic [15:0] fout_im[2];

    filter_sequencer #(.NUM_BINS(256), .MIRROR(1)) u_dut_m1 (
        .clk(clk), .rst(rst), .start(start), .cutoff_freq(cutoff),
        .busy(busy[0]), .done(done[0]), .ram_addr(ram_addr[0]),
        .ram_rd_en(rd_en[0]), .ram_rd_real(rd_re[0]), .ram_rd_imag(rd_im[0]),
        .ram_wr_en(wr_en[0]), .ram_wr_real(wr_re[0]), .ram_wr_imag(wr_im[0]),
        .filt_freq_bin(fbin[0]), .filt_cutoff(fcut[0]),
        .filt_real_in(fin_re[0]), .filt_imag_in(fin_im[0]),
        .filt_real_out(fout_re[0]), .filt_imag_out(fout_im[0])
    );

    filter_sequencer #(.NUM_BINS(256), .MIRROR(0)) u_dut_m0 (
        .clk(clk), .rst(rst), .start(start), .cutoff_freq(cutoff),
        .busy(busy[1]), .done(done[1]), .ram_addr(ram_addr[1]),
        .ram_rd_en(rd_en[1]), .ram_rd_real(rd_re[1]), .ram_rd_imag(rd_im[1]),
        .ram_wr_en(wr_en[1]), .ram_wr_real(wr_re[1]), .ram_wr_imag(wr_im[1]),
        .filt_freq_bin(fbin[1]), .filt_cutoff(fcut[1]),
        .filt_real_in(fin_re[1]), .filt_imag_in(fin_im[1]),
        .filt_real_out(fout_re[1]), .filt_imag_out(fout_im[1])
    );

    // External low-pass filter: zero every bin at or above the cutoff.
    for (genvar k = 0; k < 2; k++) begin : g_filt
        assign fout_re[k] = (fbin[k] >= fcut[k]) ? 16'h0 : fin_re[k];
        assign fout_im[k] = (fbin[k] >= fcut[k]) ? 16'h0 : fin_im[k];
    end

    // Spectrum RAMs with one-cycle read latency, preloadable from init_*.
    logic [15:0] mem_re[2][256];
    logic [15:0] mem_im[2][256];
    logic [15:0] init_re[256];
    logic [15:0] init_im[256];
    logic        load;

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (load) begin
                for (int i = 0; i < 256; i++) begin
                    mem_re[k][i] <= init_re[i];
                    mem_im[k][i] <= init_im[i];
                end
            end else begin
                if (wr_en[k]) begin
                    mem_re[k][ram_addr[k]] <= wr_re[k];
                    mem_im[k][ram_addr[k]] <= wr_im[k];
                end
                if (rd_en[k]) begin
                    rd_re[k] <= mem_re[k][ram_addr[k]];
                    rd_im[k] <= mem_im[k][ram_addr[k]];
                end
            end
        end
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference for the frequency distance of bin i.
    function automatic int fold(input int i, input bit mir);
        return (mir && i >= 128) ? 256 - i : i;
    endfunction

    logic [7:0] exp_cut;
    int last_rd[2];
    int wr_cnt[2];

    // Protocol monitor, sampled on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                wr_cnt[k] = 0;
            end else begin
                if (rd_en[k] && wr_en[k]) chk("rd_wr_exclusive", 1, 0);
                if (!rd_en[k] && !wr_en[k] && ram_addr[k] != 8'd0)
                    chk("idle_addr_zero", ram_addr[k], 0);
                if (rd_en[k]) last_rd[k] = ram_addr[k];
                if (wr_en[k]) begin
                    wr_cnt[k]++;
                    chk("wr_addr_eq_rd_addr", ram_addr[k], last_rd[k]);
                    chk("filt_freq_bin", fbin[k], fold(ram_addr[k], k == 0));
                    chk("filt_cutoff_latched", fcut[k], exp_cut);
                end
                if (done[k]) begin
                    chk("writes_per_pass", wr_cnt[k], 256);
                    chk("busy_low_with_done", busy[k], 0);
                    wr_cnt[k] = 0;
                end
            end
        end
    end

    logic [15:0] orig_re[256];
    logic [15:0] orig_im[256];

    task automatic preload(input bit rnd);
        for (int i = 0; i < 256; i++) begin
            init_re[i] = rnd ? 16'($urandom) : 16'h1234;
            init_im[i] = rnd ? 16'($urandom) : 16'h5678;
            orig_re[i] = init_re[i];
            orig_im[i] = init_im[i];
        end
        @(negedge clk); load = 1'b1;
        @(negedge clk); load = 1'b0;
    endtask

    task automatic check_mem(input logic [7:0] cut, input int ez0, input int ez1);
        for (int k = 0; k < 2; k++) begin
            int bad = 0;
            int zeroed = 0;
            for (int i = 0; i < 256; i++) begin
                bit z = fold(i, k == 0) >= int'(cut);
                if (mem_re[k][i] !== (z ? 16'h0 : orig_re[i])) bad++;
                if (mem_im[k][i] !== (z ? 16'h0 : orig_im[i])) bad++;
                if (mem_re[k][i] == 16'h0 && mem_im[k][i] == 16'h0) zeroed++;
            end
            chk(k == 0 ? "mem_contents_m1" : "mem_contents_m0", bad, 0);
            if (ez0 >= 0) chk(k == 0 ? "zeroed_bins_m1" : "zeroed_bins_m0",
                              zeroed, k == 0 ? ez0 : ez1);
        end
    endtask

    // One full pass with cycle-accurate busy/done checking. mid=1 adds stray
    // starts during the pass and in FIN plus a cutoff change mid-pass.
    task automatic run_pass(input logic [7:0] cut, input bit rnd, input bit mid,
                            input int ez0, input int ez1);
        int done_cyc = -1;
        int ndone = 0;
        int busy_err = 0;
        int done_err = 0;
        preload(rnd);
        @(negedge clk);
        cutoff = cut;
        exp_cut = cut;
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        for (int cyc = 1; cyc <= 800; cyc++) begin
            @(negedge clk);
            if (mid && (cyc == 50 || cyc == 769)) start = 1'b1;
            if (mid && (cyc == 51 || cyc == 770)) start = 1'b0;
            if (mid && cyc == 60) cutoff = 8'd0;
            for (int k = 0; k < 2; k++) begin
                if (busy[k] !== (cyc <= 768)) busy_err++;
                if (done[k] !== (cyc == 769)) done_err++;
            end
            if (done[0] === 1'b1) begin
                ndone++;
                if (done_cyc < 0) done_cyc = cyc;
            end
        end
        start = 1'b0;
        chk("done_cycle", done_cyc, 769);
        chk("done_count", ndone, 1);
        chk("busy_window_errors", busy_err, 0);
        chk("done_window_errors", done_err, 0);
        check_mem(cut, ez0, ez1);
    endtask

    function automatic int outs_nonzero(input int k);
        return int'(busy[k]) + int'(done[k]) + int'(rd_en[k]) + int'(wr_en[k])
             + int'(ram_addr[k]) + int'(wr_re[k]) + int'(wr_im[k]) + int'(fbin[k])
             + int'(fcut[k]) + int'(fin_re[k]) + int'(fin_im[k]);
    endfunction

    typedef struct {
        logic [7:0] cut;
        int         z_m1;
        int         z_m0;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{8'd10,  237, 246};
        tbl[1] = '{8'd0,   256, 256};
        tbl[2] = '{8'd200, 0,   56};
        tbl[3] = '{8'd128, 1,   128};
        tbl[4] = '{8'd129, 0,   127};
        tbl[5] = '{8'd255, 0,   1};

        rst = 1'b1; start = 1'b0; cutoff = 8'd0; load = 1'b0; exp_cut = 8'd0;
        for (int k = 0; k < 2; k++) begin last_rd[k] = -1; wr_cnt[k] = 0; end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) chk("reset_outputs", outs_nonzero(k), 0);
        @(negedge clk); rst = 1'b0;

        for (int t = 0; t < 6; t++)
            run_pass(tbl[t].cut, 1'b0, 1'b0, tbl[t].z_m1, tbl[t].z_m0);

        for (int r = 0; r < 3; r++)
            run_pass(8'($urandom_range(0, 255)), 1'b1, 1'b0, -1, -1);

        // Stray starts and a cutoff change must not disturb a pass at 100.
        run_pass(8'd100, 1'b0, 1'b1, 57, 156);

        // Reset during the WR of bin 100.
        begin
            bit found = 0;
            int seen_done = 0;
            preload(1'b0);
            @(negedge clk);
            cutoff = 8'd10; exp_cut = 8'd10; start = 1'b1;
            @(posedge clk); #1 start = 1'b0;
            for (int cyc = 0; cyc < 400 && !found; cyc++) begin
                @(negedge clk);
                if (wr_en[0] && ram_addr[0] == 8'd100) found = 1;
            end
            chk("reached_wr_100", found, 1);
            rst = 1'b1;
            #1;
            for (int k = 0; k < 2; k++) chk("midpass_reset_outputs", outs_nonzero(k), 0);
            repeat (3) @(negedge clk);
            rst = 1'b0;
            for (int cyc = 0; cyc < 10; cyc++) begin
                @(negedge clk);
                if (busy[0] || busy[1] || done[0] || done[1]) seen_done++;
            end
            chk("idle_after_reset", seen_done, 0);
            for (int k = 0; k < 2; k++) begin
                chk("bin99_written", mem_re[k][99], 0);
                chk("bin100_untouched", mem_re[k][100], 16'h1234);
                chk("bin101_untouched", mem_im[k][101], 16'h5678);
            end
        end

        run_pass(tbl[0].cut, 1'b0, 1'b0, tbl[0].z_m1, tbl[0].z_m0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/filter_sequencer.md
FILTER_SEQUENCER -- requirements
Module: filter_sequencer

Interface
REQ-001 Parameter NUM_BINS, default 256, is the number of FFT bins in spectrum RAM; it SHALL be a power of two, 4..256.
REQ-002 Parameter MIRROR, default 1: 1 = fold bins at or above NUM_BINS/2 onto their negative-frequency distance; 0 = present the raw bin index.
REQ-003 Clk  in  1  single clock; all state changes on rising edge.
REQ-004 Reset  in  1  asynchronous, active-high reset.
REQ-005 START  in  1  request one filter pass; sampled only in IDLE.
REQ-006 CUTOFF_FREQ  in  8  cutoff bin; latched on the accepted START.
REQ-007 BUSY  out  1  pass in progress.
REQ-008 DONE  out  1  one-cycle pulse when a pass completes.
REQ-009 RAM_ADDR  out  8  spectrum RAM address for both read and write.
REQ-010 RAM_RD_EN  out  1  read strobe; RAM returns data exactly 1 cycle later.
REQ-011 RAM_RD_REAL, RAM_RD_IMAG  in  16 each  RAM read data.
REQ-012 RAM_WR_EN  out  1  write strobe.
REQ-013 RAM_WR_REAL, RAM_WR_IMAG  out  16 each  RAM write data.
REQ-014 FILT_FREQ_BIN  out  8  bin index presented to the external low-pass filter.
REQ-015 FILT_CUTOFF  out  8  latched cutoff presented to the filter.
REQ-016 FILT_REAL_IN, FILT_IMAG_IN  out  16 each  captured sample presented to the filter.
REQ-017 FILT_REAL_OUT, FILT_IMAG_OUT  in  16 each  filter result; combinational relative to the filter inputs.

Function
REQ-018 The FSM SHALL have the states IDLE, RD, CAP, WR and FIN.
REQ-019 IDLE: when START=1, the block SHALL latch CUTOFF_FREQ, clear bin index idx to 0 and go to RD; otherwise it SHALL stay in IDLE.
REQ-020 RD: RAM_ADDR=idx and RAM_RD_EN=1 for one cycle; next state CAP.
REQ-021 CAP: the block SHALL register RAM_RD_REAL/IMAG into sample registers; next state WR.
REQ-022 WR: RAM_ADDR=idx, RAM_WR_EN=1, RAM_WR_REAL/IMAG=FILT_REAL_OUT/IMAG_OUT.
REQ-023 WR exit: if idx=NUM_BINS-1, next state FIN; otherwise increment idx and go to RD.
REQ-024 FIN: DONE=1 for exactly one cycle; next state IDLE.
REQ-025 FILT_FREQ_BIN SHALL be idx when MIRROR=0 or idx<NUM_BINS/2, else NUM_BINS-idx (NUM_BINS=256, idx=128 gives 128).
REQ-026 FILT_REAL_IN/IMAG_IN SHALL be driven from the sample registers; FILT_CUTOFF SHALL be driven from the latched cutoff.
REQ-027 Each bin SHALL take exactly 3 cycles; with START sampled in cycle 0, BUSY SHALL be 1 in cycles 1..3*NUM_BINS and DONE SHALL be 1 only in cycle 3*NUM_BINS+1, with BUSY=0 in that cycle.
REQ-028 START while BUSY or in FIN SHALL be ignored, with no restart or re-latch.
REQ-029 CUTOFF_FREQ changes during a pass SHALL have no effect until the next accepted START.
REQ-030 RAM_RD_EN and RAM_WR_EN SHALL never be high in the same cycle, and both SHALL be 0 outside RD/WR.
REQ-031 When not in RD or WR, RAM_ADDR SHALL be 0.
REQ-032 idx SHALL be wide enough that the NUM_BINS-1 comparison never wraps (8 bits for 256).

Reset
REQ-033 Reset=1 SHALL, asynchronously: force IDLE; clear idx, latched cutoff and sample registers to 0; drive BUSY, DONE, RAM_RD_EN and RAM_WR_EN to 0 and all data/address outputs to 0.
REQ-034 Reset mid-pass SHALL abandon the pass with no further RAM writes and no DONE pulse; bins already written stay modified.
REQ-035 After Reset deasserts, the block SHALL wait for a fresh START.

Verification
REQ-036 NUM_BINS=256, MIRROR=1, CUTOFF=10, RAM all 0x1234/0x5678, start -> bins 0..9 and 247..255 unchanged; bins 10..246 written 0/0; DONE in cycle 769 only.
REQ-037 CUTOFF=0 -> all 256 bins zeroed (filter compares >=).
REQ-038 MIRROR=0, CUTOFF=200 -> bins 0..199 kept, 200..255 zeroed; FILT_FREQ_BIN equals idx throughout.
REQ-039 START pulsed at cycle 50, with CUTOFF changed to 0 at cycle 60 -> no restart; results match the cutoff latched at the original START; a single DONE.
REQ-040 Reset asserted in the WR of idx=100 -> outputs go to 0 immediately; bin 100 not written; no DONE; next START performs a full pass.
REQ-041 Protocol checker, all runs: RD/WR exclusive; every WR address equals the preceding RD address; 256 writes per completed pass.
